sensor_ascii_formatter: RTL and testbench

Sequential, parametrised successor to the combinational sensor-to-ASCII row builder. Accepts a raw echo-time sample (µs) over a valid/ready handshake. Converts it to centimetres with an iterative shift-subtract divider, or passes raw µs through. Converts the result to BCD by multi-cycle double-dabble and registers a 16-character LCD row with saturation, overflow flag and optional leading-zero blanking. Sits between the ultrasonic sensor capture block and the LCD row driver.

---
 rtl/sensor_ascii_formatter.sv | 186 ++++++++++++++++++
 tb/tb_sensor_ascii_formatter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_ascii_formatter.sv
// Sequential sensor-to-ASCII row builder: restoring divide, multi-cycle double-dabble,
// then one formatting cycle that loads a 16-character LCD row.
module sensor_ascii_formatter #(
   parameter int IN_W   = 22,
   parameter int DIGITS = 4,
   parameter int DIV    = 58
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] sensor_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            raw_mode,
   input  logic            blank_lz,
   output logic [127:0]    ascii_row,
   output logic            row_valid,
   output logic            ovf
);
   localparam int RW = $clog2(DIV + 1) + 1;
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(IN_W + 1);
   localparam logic [63:0] MAX_Q = 64'(10 ** DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_BCD  = 2'd2,
      S_FMT  = 2'd3
   } state_t;

   function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         else                     r[4*i +: 4] = b[4*i +: 4];
      end
      return r;
   endfunction

   // digs holds the leftmost digit character in its most significant byte
   function automatic logic [127:0] make_row(input logic [8*DIGITS-1:0] digs, input logic raw);
      logic [127:0] r;
      r = {16{8'h20}};
      r[127:80] = 48'h53454E533A20;
      for (int k = 0; k < DIGITS; k++) begin
         r[127 - 8*(6+k) -: 8] = digs[8*(DIGITS-1-k) +: 8];
      end
      r[127 - 8*(7+DIGITS) -: 8] = raw ? 8'h75 : 8'h63;
      r[127 - 8*(8+DIGITS) -: 8] = raw ? 8'h73 : 8'h6D;
      return r;
   endfunction

   localparam logic [127:0] RST_ROW = make_row({DIGITS{8'h2D}}, 1'b0);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IN_W-1:0] quo_q, quo_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            raw_q, raw_d, blz_q, blz_d;
   logic [127:0]    row_q, row_d;
   logic            rv_q, rv_d, ovf_q, ovf_d;

   logic            last_s, ge_s, sat_s;
   logic [RW:0]     rem_sh_s, divisor_s;
   logic [8*DIGITS-1:0] digs_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign last_s = (cnt_q == CW'(IN_W - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_DIV; else state_d = S_IDLE;
         S_DIV:   if (last_s)   state_d = S_BCD; else state_d = S_DIV;
         S_BCD:   if (last_s)   state_d = S_FMT; else state_d = S_BCD;
         S_FMT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Digit characters with saturation and leading-zero blanking; the units digit always shows
   always_comb begin
      logic       lead;
      logic [3:0] nib;
      divisor_s = raw_q ? (RW+1)'(1) : (RW+1)'(DIV);
      rem_sh_s  = {rem_q, quo_q[IN_W-1]};
      ge_s      = (rem_sh_s >= divisor_s);
      sat_s     = (64'(quo_q) > MAX_Q);
      digs_s    = {DIGITS{8'h20}};
      lead      = blz_q;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         nib = bcd_q[4*k +: 4];
         if (sat_s) begin
            digs_s[8*k +: 8] = 8'h39;
         end else if (lead && (nib == 4'd0) && (k != 0)) begin
            digs_s[8*k +: 8] = 8'h20;
         end else begin
            digs_s[8*k +: 8] = 8'h30 + {4'd0, nib};
            lead = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      bcd_d = bcd_q;
      raw_d = raw_q;
      blz_d = blz_q;
      row_d = row_q;
      rv_d  = 1'b0;
      ovf_d = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               quo_d = sensor_data;
               rem_d = {RW{1'b0}};
               bcd_d = {BW{1'b0}};
               cnt_d = {CW{1'b0}};
               raw_d = raw_mode;
               blz_d = blank_lz;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_DIV: begin
            if (ge_s) rem_d = RW'(rem_sh_s - divisor_s);
            else      rem_d = RW'(rem_sh_s);
            quo_d = {quo_q[IN_W-2:0], ge_s};
            cnt_d = last_s ? {CW{1'b0}} : cnt_q + CW'(1);
         end
         // quotient is rotated, not shifted, so it is intact again for the saturation test
         S_BCD: begin
            bcd_d = BW'({dabble(bcd_q), quo_q[IN_W-1]});
            quo_d = {quo_q[IN_W-2:0], quo_q[IN_W-1]};
            cnt_d = last_s ? {CW{1'b0}} : cnt_q + CW'(1);
         end
         S_FMT: begin
            row_d = make_row(digs_s, raw_q);
            rv_d  = 1'b1;
            ovf_d = sat_s;
         end
         default: begin
            rv_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
         quo_q <= {IN_W{1'b0}};
         rem_q <= {RW{1'b0}};
         bcd_q <= {BW{1'b0}};
         raw_q <= 1'b0;
         blz_q <= 1'b0;
         row_q <= RST_ROW;
         rv_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         bcd_q <= bcd_d;
         raw_q <= raw_d;
         blz_q <= blz_d;
         row_q <= row_d;
         rv_q  <= rv_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      ascii_row = row_q;
      row_valid = rv_q;
      ovf       = ovf_q;
   end
endmodule

// File: tb/tb_sensor_ascii_formatter.sv
// Directed bench for sensor_ascii_formatter with default parameters (IN_W=22, DIGITS=4, DIV=58).
module tb_sensor_ascii_formatter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [21:0]  sensor_data;
   logic         in_valid;
   logic         in_ready;
   logic         raw_mode;
   logic         blank_lz;
   logic [127:0] ascii_row;
   logic         row_valid;
   logic         ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   localparam logic [127:0] RST_ROW = "SENS: ---- cm   ";

   sensor_ascii_formatter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sensor_data (sensor_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .raw_mode    (raw_mode),
      .blank_lz    (blank_lz),
      .ascii_row   (ascii_row),
      .row_valid   (row_valid),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ready"}, 128'(in_ready), 128'(1'b1));
   endtask

   // Wait for row_valid after an accept, bounded; returns edges counted
   task automatic wait_row(output int n);
      n = 0;
      while (row_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [21:0] d, input logic raw, input logic blz,
                      input logic [127:0] erow, input logic eovf);
      int n;
      wait_ready(tag);
      sensor_data = d;
      raw_mode    = raw;
      blank_lz    = blz;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      raw_mode    = ~raw;
      blank_lz    = ~blz;
      sensor_data = ~d;
      chk({tag, "_busy"}, 128'(in_ready), 128'(1'b0));
      wait_row(n);
      chk({tag, "_lat"}, 128'(n), 128'(45));
      chk({tag, "_row"}, ascii_row, erow);
      chk({tag, "_ovf"}, 128'(ovf), 128'(eovf));
      chk({tag, "_rdy_with_rv"}, 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 128'(row_valid), 128'(1'b0));
      chk({tag, "_hold"}, ascii_row, erow);
   endtask

   initial begin
      int n, t0, t1, busy_bad, seen;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      sensor_data = 22'd0;
      raw_mode    = 1'b0;
      blank_lz    = 1'b0;
      #12;
      chk("rst_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_rv",    128'(row_valid), 128'(1'b0));
      chk("rst_ovf",   128'(ovf), 128'(1'b0));
      chk("rst_row",   ascii_row, RST_ROW);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run("cm5800",    22'd5800,    1'b0, 1'b0, "SENS: 0100 cm   ", 1'b0);
      run("lz57",      22'd57,      1'b0, 1'b1, "SENS:    0 cm   ", 1'b0);
      run("lz580",     22'd580,     1'b0, 1'b1, "SENS:   10 cm   ", 1'b0);
      run("zero",      22'd0,       1'b0, 1'b0, "SENS: 0000 cm   ", 1'b0);
      run("sat_max",   22'd4194303, 1'b0, 1'b0, "SENS: 9999 cm   ", 1'b1);
      run("edge9999",  22'd579999,  1'b0, 1'b0, "SENS: 9999 cm   ", 1'b0);
      run("edge10000", 22'd580000,  1'b0, 1'b0, "SENS: 9999 cm   ", 1'b1);
      run("raw1234",   22'd1234,    1'b1, 1'b0, "SENS: 1234 us   ", 1'b0);
      run("raw_lz305", 22'd305,     1'b1, 1'b1, "SENS:  305 us   ", 1'b0);
      run("raw_lz7",   22'd7,       1'b1, 1'b1, "SENS:    7 us   ", 1'b0);

      // in_valid held high across two conversions
      wait_ready("hold");
      raw_mode    = 1'b0;
      blank_lz    = 1'b0;
      sensor_data = 22'd116;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      sensor_data = 22'd232;
      busy_bad = 0;
      n = 0;
      while (row_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (row_valid !== 1'b1 && in_ready !== 1'b0) busy_bad++;
      end
      chk("hold1_lat", 128'(n), 128'(45));
      chk("hold1_row", ascii_row, "SENS: 0002 cm   ");
      @(posedge clk); #1;
      t1 = cyc;
      chk("hold2_busy", 128'(in_ready), 128'(1'b0));
      chk("hold_gap", 128'(t1 - t0), 128'(46));
      in_valid    = 1'b0;
      sensor_data = 22'd999999;
      n = 0;
      while (row_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (row_valid !== 1'b1 && in_ready !== 1'b0) busy_bad++;
      end
      chk("hold2_lat", 128'(n), 128'(45));
      chk("hold2_row", ascii_row, "SENS: 0004 cm   ");
      chk("hold_busy_ready", 128'(busy_bad), 128'(0));
      @(posedge clk); #1;

      run("raw_sat", 22'd10000, 1'b1, 1'b0, "SENS: 9999 us   ", 1'b1);

      // reset in the middle of the divide phase
      wait_ready("midrst");
      sensor_data = 22'd5800;
      raw_mode    = 1'b1;
      blank_lz    = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 128'(in_ready), 128'(1'b1));
      chk("midrst_ovf",   128'(ovf), 128'(1'b0));
      chk("midrst_row",   ascii_row, RST_ROW);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (row_valid === 1'b1) seen++;
      end
      chk("midrst_no_rv", 128'(seen), 128'(0));
      chk("midrst_row_held", ascii_row, RST_ROW);

      run("after_rst", 22'd5800, 1'b0, 1'b0, "SENS: 0100 cm   ", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
